// File: rtl/axi2ahb_bridge.sv
// AXI4-Lite slave to AHB-Lite master bridge, one transaction outstanding.
// Latency: zero-wait write gives bvalid 3 cycles after the AW/W handshake; a read gives rvalid 3 cycles after AR.
// Backpressure: AXI readies only in IDLE; B/R held until bready/rready; AHB waits stall via hready.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b* AXI4-Lite write address, data and response channels
//   axi_ar*/axi_r*        AXI4-Lite read address and data channels
//   ahb_h*                AHB-Lite master (NONSEQ/IDLE only, single transfers)
// Build option: define AXI2AHB_WSTRB_SPLIT_EN to issue a non-contiguous or
// misaligned strobe as one byte transfer per set lane (ascending). Without it,
// such a strobe goes out as one full-width transfer at the aligned address.
module axi2ahb_bridge #(
    parameter int P_AW         = 32,
    parameter int P_DW         = 32,
    parameter int P_USE_ARSIZE = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [P_AW-1:0]     axi_awaddr,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [P_DW-1:0]     axi_wdata,
    input  logic [P_DW/8-1:0]   axi_wstrb,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [P_AW-1:0]     axi_araddr,
    input  logic [2:0]          axi_arsize,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [P_DW-1:0]     axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rvalid,
    input  logic                axi_rready,
    output logic [P_AW-1:0]     ahb_haddr,
    output logic [2:0]          ahb_hsize,
    output logic [1:0]          ahb_htrans,
    output logic                ahb_hwrite,
    output logic [P_DW-1:0]     ahb_hwdata,
    input  logic [P_DW-1:0]     ahb_hrdata,
    input  logic                ahb_hresp,
    input  logic                ahb_hready
);

    localparam int          NB       = P_DW / 8;
    localparam int          LB       = $clog2(NB);
    localparam logic [2:0]  MAX_SIZE = 3'(LB);
    localparam logic        GRANT_RD = 1'b1;
    localparam logic [1:0]  RESP_OK  = 2'b00;
    localparam logic [1:0]  RESP_ERR = 2'b10;
`ifdef AXI2AHB_WSTRB_SPLIT_EN
    localparam logic        SPLIT    = 1'b1;
`else
    localparam logic        SPLIT    = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_RADDR, S_RDATA, S_BRESP, S_RRESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [P_AW-1:0]   haddr_q, haddr_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [P_DW-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]     strb_q, strb_d;     // lanes still to be issued after the current transfer
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [P_DW-1:0]   rdata_q, rdata_d;
    logic              aw_rdy, ar_rdy;

    // Strobe decode, shared by the first transfer (incoming wstrb) and each
    // follow-on split byte (remaining lanes).
    logic [NB-1:0]     dec_strb, dec_rem;
    logic [2:0]        dec_size;
    logic [LB-1:0]     dec_lane, low_lane;
    logic              dec_ok;
    logic [2:0]        rd_size;

    always_comb begin
        dec_strb = (state_q == S_IDLE) ? axi_wstrb : strb_q;
        low_lane = '0;
        for (int l = NB - 1; l >= 0; l--) begin
            if (dec_strb[l]) low_lane = LB'(l);
        end
        dec_ok   = 1'b0;
        dec_size = MAX_SIZE;
        dec_lane = '0;
        dec_rem  = '0;
        // A naturally aligned power-of-two run of lanes maps onto one transfer.
        for (int s = 0; s <= LB; s++) begin
            for (int l = 0; l < NB; l += (1 << s)) begin
                if (dec_strb == NB'(((1 << (1 << s)) - 1) << l)) begin
                    dec_ok   = 1'b1;
                    dec_size = 3'(s);
                    dec_lane = LB'(l);
                end
            end
        end
        if (!dec_ok && SPLIT) begin
            dec_size = 3'd0;
            dec_lane = low_lane;
            dec_rem  = dec_strb & ~(NB'(1) << low_lane);
        end
    end

    assign rd_size = (P_USE_ARSIZE == 0)    ? MAX_SIZE :
                     (axi_arsize > MAX_SIZE) ? MAX_SIZE : axi_arsize;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        haddr_d      = haddr_q;
        hsize_d      = hsize_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        bresp_d      = bresp_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        aw_rdy       = 1'b0;
        ar_rdy       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // With both pending, the type not served last wins.
                if (axi_awvalid && axi_wvalid && (!axi_arvalid || last_grant_q == GRANT_RD)) begin
                    aw_rdy              = 1'b1;
                    wdata_d             = axi_wdata;
                    bresp_d             = RESP_OK;
                    haddr_d             = axi_awaddr;
                    haddr_d[LB-1:0]     = dec_lane;
                    hsize_d             = dec_size;
                    strb_d              = dec_rem;
                    state_d             = (axi_wstrb == '0) ? S_BRESP : S_WADDR;
                end else if (axi_arvalid) begin
                    ar_rdy  = 1'b1;
                    haddr_d = axi_araddr;
                    hsize_d = rd_size;
                    state_d = S_RADDR;
                end
            end
            S_WADDR: if (ahb_hready) state_d = S_WDATA;
            S_WDATA: begin
                if (ahb_hready) begin
                    if (ahb_hresp) begin
                        bresp_d = RESP_ERR;
                        strb_d  = '0;
                        state_d = S_BRESP;
                    end else if (strb_q != '0) begin
                        haddr_d[LB-1:0] = dec_lane;
                        hsize_d         = dec_size;
                        strb_d          = dec_rem;
                        state_d         = S_WADDR;
                    end else begin
                        state_d = S_BRESP;
                    end
                end
            end
            S_RADDR: if (ahb_hready) state_d = S_RDATA;
            S_RDATA: begin
                if (ahb_hready) begin
                    rdata_d = ahb_hrdata;
                    rresp_d = ahb_hresp ? RESP_ERR : RESP_OK;
                    state_d = S_RRESP;
                end
            end
            S_BRESP: begin
                if (axi_bready) begin
                    last_grant_d = ~GRANT_RD;
                    state_d      = S_IDLE;
                end
            end
            S_RRESP: begin
                if (axi_rready) begin
                    last_grant_d = GRANT_RD;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_RD;
            haddr_q      <= '0;
            hsize_q      <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            bresp_q      <= '0;
            rresp_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            haddr_q      <= haddr_d;
            hsize_q      <= hsize_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
        end
    end

    // Readies are combinational on the valids; gate them so nothing is
    // accepted while reset is held.
    assign axi_awready = aw_rdy && reset_n;
    assign axi_wready  = aw_rdy && reset_n;
    assign axi_arready = ar_rdy && reset_n;
    assign axi_bvalid  = (state_q == S_BRESP);
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = (state_q == S_RRESP);
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;
    assign ahb_htrans  = (state_q == S_WADDR || state_q == S_RADDR) ? 2'b10 : 2'b00;
    assign ahb_hwrite  = (state_q == S_WADDR);
    assign ahb_haddr   = haddr_q;
    assign ahb_hsize   = hsize_q;
    assign ahb_hwdata  = wdata_q;

endmodule

// File: tb/tb_axi2ahb_bridge.sv
// Directed bench for axi2ahb_bridge with P_DW=32 and a small AHB slave model.
// Latency: checks bvalid/rvalid arrival cycles against the hand-computed values.
// Backpressure: exercises AHB wait states, two-cycle ERROR and bready hold.
module tb_axi2ahb_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arsize;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid, axi_rready;
    logic [31:0] ahb_haddr;
    logic [2:0]  ahb_hsize;
    logic [1:0]  ahb_htrans;
    logic        ahb_hwrite;
    logic [31:0] ahb_hwdata;
    logic [31:0] ahb_hrdata;
    logic        ahb_hresp, ahb_hready;

    always #5 clk = ~clk;

    axi2ahb_bridge #(.P_AW(32), .P_DW(32), .P_USE_ARSIZE(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
        .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata), .ahb_hresp(ahb_hresp), .ahb_hready(ahb_hready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // AHB slave model: programmable data-phase wait states and per-transfer
    // two-cycle ERROR; logs every accepted address phase.
    int          slv_waits = 0;
    logic [7:0]  slv_err_mask = '0;
    logic [31:0] slv_rdata = '0;
    int          log_n = 0;
    logic [31:0] log_addr [8];
    logic [2:0]  log_size [8];
    logic        log_write [8];
    logic [31:0] log_wdata [8];
    logic        dp_active, dp_err, dp_err_seen, dp_write;
    int          dp_wait, dp_idx;

    initial begin
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        ahb_hrdata = '0;
        dp_active  = 1'b0;
        dp_err = 1'b0; dp_err_seen = 1'b0; dp_write = 1'b0;
        dp_wait = 0; dp_idx = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dp_active  = 1'b0;
                ahb_hready = 1'b1;
                ahb_hresp  = 1'b0;
            end else begin
                if (dp_active) begin
                    if (dp_wait > 0) begin
                        ahb_hready = 1'b0; ahb_hresp = 1'b0; dp_wait--;
                    end else if (dp_err && !dp_err_seen) begin
                        ahb_hready = 1'b0; ahb_hresp = 1'b1; dp_err_seen = 1'b1;
                    end else begin
                        ahb_hready = 1'b1; ahb_hresp = dp_err; ahb_hrdata = slv_rdata;
                        if (dp_write) log_wdata[dp_idx] = ahb_hwdata;
                        dp_active = 1'b0;
                    end
                end else begin
                    ahb_hready = 1'b1; ahb_hresp = 1'b0;
                end
                if (!dp_active && ahb_htrans == 2'b10 && ahb_hready && log_n < 8) begin
                    log_addr[log_n]  = ahb_haddr;
                    log_size[log_n]  = ahb_hsize;
                    log_write[log_n] = ahb_hwrite;
                    dp_active   = 1'b1;
                    dp_wait     = slv_waits;
                    dp_err      = slv_err_mask[log_n];
                    dp_err_seen = 1'b0;
                    dp_write    = ahb_hwrite;
                    dp_idx      = log_n;
                    log_n++;
                end
            end
        end
    end

    // lat counts cycles after the handshake edge until bvalid is seen.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int hold, output logic [1:0] resp, output int lat);
        int   n;
        logic held;
        @(negedge clk);
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = (hold == 0);
        #1;
        n = 0;
        while (!(axi_awready && axi_wready) && n < 50) begin @(negedge clk); #1; n++; end
        check_val("aw_w_handshake", axi_awready && axi_wready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        lat = 1;
        while (!axi_bvalid && lat < 100) begin @(negedge clk); lat++; end
        check_val("bvalid_seen", axi_bvalid, 1);
        resp = axi_bresp;
        if (hold > 0) begin
            held = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!axi_bvalid || axi_bresp !== resp) held = 1'b0;
            end
            check_val("bvalid_hold", held, 1);
            axi_bready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_val("bvalid_drop", axi_bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        axi_araddr = addr; axi_arsize = size; axi_arvalid = 1'b1; axi_rready = 1'b1;
        #1;
        n = 0;
        while (!axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        check_val("ar_handshake", axi_arready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_arvalid = 1'b0;
        lat = 1;
        while (!axi_rvalid && lat < 100) begin @(negedge clk); lat++; end
        check_val("rvalid_seen", axi_rvalid, 1);
        data = axi_rdata;
        resp = axi_rresp;
        @(posedge clk);
        @(negedge clk);
        check_val("rvalid_drop", axi_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          exp_n, exp_lat;
    logic [31:0] exp_a0;
    logic [2:0]  exp_s0;
    logic        grants [4];
    int          gcnt, n;

    initial begin
        reset_n = 1'b0;
        axi_awaddr = '0; axi_wdata = '0; axi_wstrb = '0; axi_araddr = '0; axi_arsize = '0;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        axi_bready = 1'b1; axi_rready = 1'b1;
        #2;
        check_val("rst_awready", axi_awready, 0);
        check_val("rst_arready", axi_arready, 0);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_htrans", ahb_htrans, 2'b00);
        check_val("rst_hwrite", ahb_hwrite, 0);
        check_val("rst_haddr", ahb_haddr, 0);
        check_val("rst_hsize", ahb_hsize, 0);
        check_val("rst_hwdata", ahb_hwdata, 0);
        check_val("rst_bvalid", axi_bvalid, 0);
        check_val("rst_rvalid", axi_rvalid, 0);
        check_val("rst_bresp", axi_bresp, 0);
        check_val("rst_rresp", axi_rresp, 0);
        check_val("rst_rdata", axi_rdata, 0);
        reset_n = 1'b1;

        // Full-strobe zero-wait write
        log_n = 0;
        do_write(32'h100, 32'hA5A5_1234, 4'hF, 0, resp, lat);
        check_val("w1_count", log_n, 1);
        check_val("w1_haddr", log_addr[0], 32'h100);
        check_val("w1_hsize", log_size[0], 3'd2);
        check_val("w1_hwrite", log_write[0], 1);
        check_val("w1_hwdata", log_wdata[0], 32'hA5A5_1234);
        check_val("w1_bresp", resp, 2'b00);
        check_val("w1_latency", lat, 3);

        // Single byte lane 2
        log_n = 0;
        do_write(32'h200, 32'h00CC_0000, 4'h4, 0, resp, lat);
        check_val("w2_count", log_n, 1);
        check_val("w2_haddr", log_addr[0], 32'h202);
        check_val("w2_hsize", log_size[0], 3'd0);
        check_val("w2_hwdata", log_wdata[0], 32'h00CC_0000);

        // Aligned upper half
        log_n = 0;
        do_write(32'h300, 32'hBEEF_0000, 4'hC, 0, resp, lat);
        check_val("w3_haddr", log_addr[0], 32'h302);
        check_val("w3_hsize", log_size[0], 3'd1);

        // Non-contiguous strobe 0x5
`ifdef AXI2AHB_WSTRB_SPLIT_EN
        exp_n = 2; exp_a0 = 32'h200; exp_s0 = 3'd0; exp_lat = 5;
`else
        exp_n = 1; exp_a0 = 32'h200; exp_s0 = 3'd2; exp_lat = 3;
`endif
        log_n = 0;
        do_write(32'h200, 32'h0011_0022, 4'h5, 0, resp, lat);
        check_val("w4_count", log_n, exp_n);
        check_val("w4_haddr0", log_addr[0], exp_a0);
        check_val("w4_hsize0", log_size[0], exp_s0);
        check_val("w4_latency", lat, exp_lat);
        check_val("w4_bresp", resp, 2'b00);
`ifdef AXI2AHB_WSTRB_SPLIT_EN
        check_val("w4_haddr1", log_addr[1], 32'h202);
        check_val("w4_hsize1", log_size[1], 3'd0);
        check_val("w4_hwdata1", log_wdata[1], 32'h0011_0022);
`endif

        // Empty strobe: no AHB transfer, immediate OKAY
        log_n = 0;
        do_write(32'h400, 32'h1, 4'h0, 0, resp, lat);
        check_val("w5_count", log_n, 0);
        check_val("w5_bresp", resp, 2'b00);
        check_val("w5_latency", lat, 1);

        // One wait state
        slv_waits = 1; log_n = 0;
        do_write(32'h104, 32'h5555_AAAA, 4'hF, 0, resp, lat);
        check_val("w6_latency", lat, 4);
        slv_waits = 0;

        // Read with 3 wait states
        slv_waits = 3; slv_rdata = 32'hDEAD_BEEF; log_n = 0;
        do_read(32'h40, 3'd1, rd, resp, lat);
        check_val("r1_haddr", log_addr[0], 32'h40);
        check_val("r1_hsize", log_size[0], 3'd1);
        check_val("r1_hwrite", log_write[0], 0);
        check_val("r1_rdata", rd, 32'hDEAD_BEEF);
        check_val("r1_rresp", resp, 2'b00);
        check_val("r1_latency", lat, 6);
        slv_waits = 0;

        // Read two-cycle ERROR
        slv_err_mask = 8'h01; slv_rdata = 32'h1234_5678; log_n = 0;
        do_read(32'h44, 3'd2, rd, resp, lat);
        check_val("r2_rresp", resp, 2'b10);
        check_val("r2_latency", lat, 4);
        slv_err_mask = 8'h00;

        // arsize above bus width is clipped
        log_n = 0; slv_rdata = 32'h0BAD_F00D;
        do_read(32'h48, 3'd3, rd, resp, lat);
        check_val("r3_hsize", log_size[0], 3'd2);
        check_val("r3_rdata", rd, 32'h0BAD_F00D);

        // ERROR on first byte of a 0x5 strobe: nothing further issued
        slv_err_mask = 8'h01; log_n = 0;
        do_write(32'h200, 32'h0011_0022, 4'h5, 0, resp, lat);
        check_val("w7_count", log_n, 1);
        check_val("w7_bresp", resp, 2'b10);
        slv_err_mask = 8'h00;

        // Following write responds OKAY again; bvalid held 5 cycles with bready low
        log_n = 0;
        do_write(32'h108, 32'h0000_00FF, 4'hF, 5, resp, lat);
        check_val("w8_bresp", resp, 2'b00);

        // Reset during WDATA
        slv_waits = 5;
        @(negedge clk);
        axi_awaddr = 32'h500; axi_wdata = 32'h7777_7777; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        #1;
        check_val("rst_mid_awready", axi_awready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        check_val("rst_mid_waddr_htrans", ahb_htrans, 2'b10);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_htrans", ahb_htrans, 2'b00);
        check_val("rst_mid_hwrite", ahb_hwrite, 0);
        check_val("rst_mid_bvalid", axi_bvalid, 0);
        check_val("rst_mid_rvalid", axi_rvalid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        slv_waits = 0;
        log_n = 0;
        do_write(32'h10C, 32'hCAFE_0001, 4'hF, 0, resp, lat);
        check_val("post_rst_latency", lat, 3);
        check_val("post_rst_bresp", resp, 2'b00);

        // Continuous read and write pending from reset: W, R, W, R
        @(negedge clk);
        reset_n = 1'b0;
        axi_awaddr = 32'h600; axi_wdata = 32'h1111_2222; axi_wstrb = 4'hF;
        axi_araddr = 32'h80; axi_arsize = 3'd2;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        axi_bready = 1'b1; axi_rready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        gcnt = 0; n = 0;
        while (gcnt < 4 && n < 60) begin
            #1;
            if (axi_awready) begin grants[gcnt] = 1'b1; gcnt++; end
            else if (axi_arready) begin grants[gcnt] = 1'b0; gcnt++; end
            n++;
            if (gcnt < 4) @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        repeat (8) @(negedge clk);
        check_val("arb_count", gcnt, 4);
        check_val("arb_g0_write", grants[0], 1);
        check_val("arb_g1_write", grants[1], 0);
        check_val("arb_g2_write", grants[2], 1);
        check_val("arb_g3_write", grants[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
